// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan controller.
//   SEG_BLANK : all segments off (active-low pattern)
//   HEX_SEG   : hex nibble -> active-low {g,f,e,d,c,b,a} pattern
//   state_t   : scan FSM states (BLANK gap / DRIVE digit)
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex-to-7-segment decoder.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  active-low segment pattern {g,f,e,d,c,b,a}
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; the table lives in the package so it is shared.
  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment scan controller.
// Each digit slot is CLK_DIV cycles: BLANK_CYCLES with all anodes off
// (anti-ghosting), then the digit is driven. Host writes land in a pending
// register and are copied to the displayed (shadow) data only at the frame
// boundary, so a frame is never shown half old / half new.
// Ports:
//   clk         in   1             system clock
//   rst         in   1             synchronous reset, active-high
//   wr_valid    in   1             host write request
//   wr_ready    out  1             pending register free
//   wr_data     in   4*NUM_DIGITS  hex nibbles, digit k = wr_data[4k+3:4k]
//   wr_dp       in   NUM_DIGITS    decimal-point enables, bit k = digit k
//   an          out  NUM_DIGITS    anode enables, active-low (flopped)
//   seg         out  7             segments {g..a}, active-low (flopped)
//   dp          out  1             decimal point, active-low (flopped)
//   frame_done  out  1             one-cycle pulse in the last cycle of a frame
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN  blank leading zero digits (digit 0 never blanked)
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic [4*NUM_DIGITS-1:0] shadow_data, pend_data;
  logic [NUM_DIGITS-1:0]   shadow_dp, pend_dp;
  logic                    pend_full;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic [6:0]              seg_nx;
  logic                    dp_nx;
  logic                    frame_nx;
  logic                    cnt_wrap;
  logic                    boundary;
  logic [3:0]              cur_nibble;
  logic [6:0]              hex_seg;
  logic [6:0]              seg_drive;

  assign wr_ready   = ~pend_full;
  assign cnt_wrap   = (cnt == CNT_LAST);
  assign boundary   = cnt_wrap && (idx == IDX_LAST);
  assign cur_nibble = shadow_data[{idx, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (hex_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_blank;
  logic                  higher_blank;

  // Walk from the top digit down: a digit is a leading zero only while every
  // digit above it is also a leading zero. Digit 0 is never blanked.
  always_comb begin
    lead_blank   = '0;
    higher_blank = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lead_blank[k] = higher_blank && (shadow_data[4*k +: 4] == 4'h0);
      higher_blank  = lead_blank[k];
    end
  end

  assign seg_drive = lead_blank[idx] ? SEG_BLANK : hex_seg;
`else
  assign seg_drive = hex_seg;
`endif

  // Next-state logic. The output flops are loaded with the values that belong
  // to the *next* counter position, so the pins line up exactly with the
  // slot counter: BLANK_CYCLES blank cycles, then the driven digit.
  // DRIVE always ends on a counter wrap, so idx is stable whenever the next
  // state is DRIVE and the current digit's data can be used directly.
  always_comb begin
    cnt_nx   = cnt_wrap ? '0 : cnt + CNT_W'(1);
    idx_nx   = idx;
    state_nx = state;
    an_nx    = '1;
    seg_nx   = SEG_BLANK;
    dp_nx    = 1'b1;

    if (cnt_wrap) begin
      idx_nx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end

    case (state)
      BLANK:   if (cnt_nx == CNT_BLANK) state_nx = DRIVE;
      DRIVE:   if (cnt_wrap)            state_nx = BLANK;
      default: state_nx = BLANK;
    endcase

    if (state_nx == DRIVE) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_nx[k] = !(idx == IDX_W'(k));
      end
      seg_nx = seg_drive;
      dp_nx  = ~shadow_dp[idx];
    end

    frame_nx = (cnt_nx == CNT_LAST) && (idx_nx == IDX_LAST);
  end

  // State, counters, flopped outputs and the write handshake. A boundary
  // with a full pending register and an accept can never coincide (accept
  // needs the register empty), so a word accepted on a boundary waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_full   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      an         <= an_nx;
      seg        <= seg_nx;
      dp         <= dp_nx;
      frame_done <= frame_nx;

      if (boundary && pend_full) begin
        shadow_data <= pend_data;
        shadow_dp   <= pend_dp;
        pend_full   <= 1'b0;
      end else if (wr_valid && !pend_full) begin
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl with
// NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2. Accepted writes are queued in a
// scoreboard and popped into the expected display image at frame boundaries;
// every scan cycle the pins are compared against that image.
// Build with SEG7_LEADING_ZERO_BLANK_EN to check leading-zero blanking.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dpv;
  } word_t;

  word_t       pend_q[$];
  logic [15:0] disp_data;
  logic [3:0]  disp_dp;
  int          cyc;
  int          total;
  int          bad;
  logic        last_accept;

  logic [6:0] hex_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .CLK_DIV      (CD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // Expected segment pattern for a digit of the current display image.
  function automatic logic [6:0] expSeg(input int digit);
    logic [3:0] nib;
    logic       blank;
    nib = disp_data[digit*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (digit != 0) begin
      blank = 1'b1;
      for (int k = digit; k < ND; k++) begin
        if (disp_data[k*4 +: 4] != 4'h0) blank = 1'b0;
      end
      if (blank) return 7'h7F;
    end
`else
    blank = 1'b0;
`endif
    return hex_ref[nib];
  endfunction

  task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare all outputs of the current scan cycle with the expected image.
  task automatic checkOutput();
    int         pos, digit, off;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    pos   = cyc % FRAME;
    digit = pos / CD;
    off   = pos % CD;
    if (off < BC) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << digit);
      e_seg = expSeg(digit);
      e_dp  = ~disp_dp[digit];
    end
    compareValue("an", 32'(an), 32'(e_an));
    compareValue("seg", 32'(seg), 32'(e_seg));
    compareValue("dp", 32'(dp), 32'(e_dp));
    compareValue("frame_done", 32'(frame_done), 32'(pos == FRAME - 1));
    compareValue("wr_ready", 32'(wr_ready), 32'(pend_q.size() == 0));
  endtask

  // One scan cycle: check, then model the boundary (pop before push so a word
  // accepted on the boundary cycle waits a frame), then the handshake.
  task automatic tick();
    logic  rdy_model;
    word_t w;
    rdy_model = (pend_q.size() == 0);
    checkOutput();
    if ((cyc % FRAME == FRAME - 1) && (pend_q.size() > 0)) begin
      w         = pend_q.pop_front();
      disp_data = w.data;
      disp_dp   = w.dpv;
    end
    last_accept = 1'b0;
    if (wr_valid && rdy_model) begin
      w.data = wr_data;
      w.dpv  = wr_dp;
      pend_q.push_back(w);
      last_accept = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic waitPos(input int p);
    for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) tick();
  endtask

  // Hold a write until the modelled handshake accepts it (bounded).
  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dpv);
    logic acc;
    wr_valid = 1'b1;
    wr_data  = data;
    wr_dp    = dpv;
    acc      = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      tick();
      acc = last_accept;
    end
    wr_valid = 1'b0;
    total++;
    assert (acc === 1'b1) else begin
      bad++;
      $error("[TB] FAIL accept_timeout data=%0h got=%0b want=1", data, acc);
    end
  endtask

  // Reset for two cycles; outputs must be at reset values after the first.
  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    compareValue("rst_an", 32'(an), 32'(4'hF));
    compareValue("rst_seg", 32'(seg), 32'(7'h7F));
    compareValue("rst_dp", 32'(dp), 32'(1'b1));
    compareValue("rst_frame_done", 32'(frame_done), 32'(1'b0));
    compareValue("rst_wr_ready", 32'(wr_ready), 32'(1'b1));
    @(negedge clk);
    rst       = 1'b0;
    cyc       = 0;
    pend_q.delete();
    disp_data = 16'h0000;
    disp_dp   = 4'h0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cyc         = 0;
    last_accept = 1'b0;
    disp_data   = 16'h0000;
    disp_dp     = 4'h0;
    wr_valid    = 1'b0;
    wr_data     = 16'h0000;
    wr_dp       = 4'h0;
    rst         = 1'b1;

    $display("[TB] reset and idle scan");
    doReset();
    runCycles(40);

    $display("[TB] mid-frame write 1A8F dp=0010");
    applyStimulus(16'h1A8F, 4'b0010);
    runCycles(50);

    $display("[TB] back-to-back writes");
    applyStimulus(16'h2345, 4'b1000);
    applyStimulus(16'h6789, 4'b0001);
    runCycles(80);

    $display("[TB] write accepted on the frame boundary cycle");
    waitPos(FRAME - 1);
    applyStimulus(16'hBCDE, 4'b0100);
    runCycles(70);

    $display("[TB] leading zero patterns");
    applyStimulus(16'h0030, 4'b0000);
    runCycles(70);
    applyStimulus(16'h0000, 4'b0000);
    runCycles(70);

    $display("[TB] reset during digit 2 drive with pending full");
    waitPos(1);
    applyStimulus(16'hFFFF, 4'hF);
    waitPos(20);
    doReset();
    runCycles(70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
